// File: rtl/decode_issue_fifo_pkg.sv
// Shared constants for the decode-to-issue queue.
package decode_issue_fifo_pkg;

  localparam int unsigned ISSUE_FIFO_DEPTH = 32'd4;

endpackage

// File: rtl/decode_issue_fifo_if.sv
// Decode/issue handshake bundle; master drives decode side and issue ack, slave is the queue.
interface decode_issue_fifo_if
  import decode_issue_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = ISSUE_FIFO_DEPTH,
  parameter type sbe_t = logic
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic              flush;
  sbe_t              decoded_instr;
  logic [31:0]       orig_instr;
  logic              is_ctrl_flow;
  logic              decoded_instr_valid;
  logic              decoded_instr_ack;
  sbe_t              issue_instr;
  logic [31:0]       issue_orig_instr;
  logic              issue_is_ctrl_flow;
  logic              issue_instr_valid;
  logic              issue_ack;
  sbe_t              issue_instr_prev;
  logic              issue_prev_valid;
  logic [PTR_W:0]    count;

  modport master (
    output flush, decoded_instr, orig_instr, is_ctrl_flow, decoded_instr_valid, issue_ack,
    input  decoded_instr_ack, issue_instr, issue_orig_instr, issue_is_ctrl_flow,
           issue_instr_valid, issue_instr_prev, issue_prev_valid, count
  );

  modport slave (
    input  flush, decoded_instr, orig_instr, is_ctrl_flow, decoded_instr_valid, issue_ack,
    output decoded_instr_ack, issue_instr, issue_orig_instr, issue_is_ctrl_flow,
           issue_instr_valid, issue_instr_prev, issue_prev_valid, count
  );

endinterface

// File: rtl/decode_issue_fifo_chk.sv
// Protocol and occupancy properties of the decode-to-issue queue.
module decode_issue_fifo_chk #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 1
) (
  input logic                     clk_i,
  input logic                     rst_i,
  input logic                     flush,
  input logic                     decoded_instr_ack,
  input logic                     issue_instr_valid,
  input logic                     issue_ack,
  input logic [$clog2(DEPTH):0]   count,
  input logic [W-1:0]             head
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  count_bound_a: assert property (@(posedge clk_i) disable iff (rst_i)
    count <= CW'(DEPTH));

  no_push_full_a: assert property (@(posedge clk_i) disable iff (rst_i)
    decoded_instr_ack |-> (count < CW'(DEPTH)));

  no_pop_empty_a: assert property (@(posedge clk_i) disable iff (rst_i)
    issue_instr_valid == (count != CW'(0)));

  head_stable_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (issue_instr_valid && !issue_ack && !flush) |=> $stable(head));

endmodule

// File: rtl/decode_issue_fifo.sv
// Decoupling queue between decode and issue; also exposes the most recently issued entry.
module decode_issue_fifo
  import decode_issue_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = ISSUE_FIFO_DEPTH,
  parameter type scoreboard_entry_t = logic
) (
  input  logic              clk_i,
  input  logic              rst_i,
  decode_issue_fifo_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    scoreboard_entry_t sbe;
    logic [31:0]       orig;
    logic              ctrl_flow;
  } entry_t;

  entry_t            mem_r [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W:0]    count_r;
  scoreboard_entry_t prev_r;
  logic              prev_valid_r;

  logic              empty_s;
  logic              full_s;
  logic              push_s;
  logic              pop_s;
  entry_t            head_s;

  // Handshake qualification; flush suppresses both push and pop.
  always_comb begin
    empty_s = (count_r == (PTR_W+1)'(0));
    full_s  = (count_r == (PTR_W+1)'(DEPTH));
    push_s  = bus.decoded_instr_valid && !full_s && !bus.flush;
    pop_s   = !empty_s && bus.issue_ack && !bus.flush;
  end

  // Head view; an empty queue presents zeros rather than stale storage.
  always_comb begin
    head_s = entry_t'(0);
    if (!empty_s) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = entry_t'(0);
    end
  end

  // Output drive.
  always_comb begin
    bus.decoded_instr_ack  = push_s;
    bus.issue_instr_valid  = !empty_s;
    bus.issue_instr        = head_s.sbe;
    bus.issue_orig_instr   = head_s.orig;
    bus.issue_is_ctrl_flow = head_s.ctrl_flow;
    bus.issue_instr_prev   = prev_r;
    bus.issue_prev_valid   = prev_valid_r;
    bus.count              = count_r;
  end

  // Storage is data only and carries no reset.
  always_ff @(posedge clk_i) begin
    if (push_s && !rst_i) begin
      mem_r[wr_ptr_r] <= '{sbe: bus.decoded_instr, orig: bus.orig_instr, ctrl_flow: bus.is_ctrl_flow};
    end
  end

  // Pointer, occupancy and prev bookkeeping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_r     <= PTR_W'(0);
      wr_ptr_r     <= PTR_W'(0);
      count_r      <= (PTR_W+1)'(0);
      prev_r       <= scoreboard_entry_t'(0);
      prev_valid_r <= 1'b0;
    end else if (bus.flush) begin
      // prev data is left stale on purpose; prev_valid alone qualifies it
      rd_ptr_r     <= PTR_W'(0);
      wr_ptr_r     <= PTR_W'(0);
      count_r      <= (PTR_W+1)'(0);
      prev_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r     <= rd_ptr_r + PTR_W'(1);
        prev_r       <= head_s.sbe;
        prev_valid_r <= 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_issue_fifo.sv
// Directed plus randomized bench for decode_issue_fifo against a queue-based model.
module tb_decode_issue_fifo;
  import decode_issue_fifo_pkg::*;

  localparam int DEPTH = 4;
  typedef logic [15:0] sbe_t;
  typedef struct packed {
    sbe_t        sbe;
    logic [31:0] orig;
    logic        cf;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  ent_t q[$];
  sbe_t prev_m = 16'h0;
  logic prev_v_m = 1'b0;
  sbe_t first_sbe;

  decode_issue_fifo_if #(.DEPTH(DEPTH), .sbe_t(sbe_t)) bus ();

  decode_issue_fifo #(.DEPTH(DEPTH), .scoreboard_entry_t(sbe_t)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  decode_issue_fifo_chk #(.DEPTH(DEPTH), .W(49)) chk_i (
    .clk_i             (clk),
    .rst_i             (rst),
    .flush             (bus.flush),
    .decoded_instr_ack (bus.decoded_instr_ack),
    .issue_instr_valid (bus.issue_instr_valid),
    .issue_ack         (bus.issue_ack),
    .count             (bus.count),
    .head              ({bus.issue_instr, bus.issue_orig_instr, bus.issue_is_ctrl_flow})
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(string tag);
    sbe_t        es;
    logic [31:0] eo;
    logic        ec;
    logic        eack;
    if (q.size() != 0) begin
      es = q[0].sbe; eo = q[0].orig; ec = q[0].cf;
    end else begin
      es = 16'h0; eo = 32'h0; ec = 1'b0;
    end
    eack = (q.size() < DEPTH) && bus.decoded_instr_valid && !bus.flush;
    chk({tag, ".ack"},   32'(bus.decoded_instr_ack), 32'(eack));
    chk({tag, ".valid"}, 32'(bus.issue_instr_valid), 32'(q.size() != 0));
    chk({tag, ".count"}, 32'(bus.count), 32'(q.size()));
    chk({tag, ".sbe"},   32'(bus.issue_instr), 32'(es));
    chk({tag, ".orig"},  bus.issue_orig_instr, eo);
    chk({tag, ".cf"},    32'(bus.issue_is_ctrl_flow), 32'(ec));
    chk({tag, ".pv"},    32'(bus.issue_prev_valid), 32'(prev_v_m));
    chk({tag, ".prev"},  32'(bus.issue_instr_prev), 32'(prev_m));
  endtask

  task automatic drive(logic v, logic a, logic f, logic [31:0] orig);
    bus.decoded_instr_valid = v;
    bus.issue_ack           = a;
    bus.flush               = f;
    bus.decoded_instr       = sbe_t'($urandom);
    bus.orig_instr          = orig;
    bus.is_ctrl_flow        = 1'($urandom);
  endtask

  // One clock: check against the model, then advance the model by the queue rules.
  task automatic step(string tag);
    logic do_push, do_pop, fl;
    ent_t e;
    #1;
    check_model(tag);
    fl      = bus.flush;
    do_push = bus.decoded_instr_valid && (q.size() < DEPTH) && !fl;
    do_pop  = (q.size() != 0) && bus.issue_ack && !fl;
    e       = '{sbe: bus.decoded_instr, orig: bus.orig_instr, cf: bus.is_ctrl_flow};
    @(posedge clk);
    if (fl) begin
      q.delete();
      prev_v_m = 1'b0;
    end else begin
      if (do_pop) begin
        prev_m   = q[0].sbe;
        prev_v_m = 1'b1;
        void'(q.pop_front());
      end
      if (do_push) q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    prev_m   = 16'h0;
    prev_v_m = 1'b0;
  endtask

  initial begin
    // Reset state
    reset_dut();
    #1;
    check_model("reset");
    chk("reset.count", 32'(bus.count), 32'd0);
    chk("reset.valid", 32'(bus.issue_instr_valid), 32'd0);

    // 1: single push, visible one cycle later
    drive(1'b1, 1'b0, 1'b0, 32'h00000013);
    #1;
    chk("t1.ack_push_cycle", 32'(bus.decoded_instr_ack), 32'd1);
    chk("t1.no_bypass", 32'(bus.issue_instr_valid), 32'd0);
    step("t1.push");
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("t1.valid", 32'(bus.issue_instr_valid), 32'd1);
    chk("t1.head",  bus.issue_orig_instr, 32'h00000013);
    chk("t1.count", 32'(bus.count), 32'd1);
    step("t1.idle");

    // 2: fill, hold a fifth offer, one ack frees a slot next cycle
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h100 + 32'(i));
      step("t2.fill");
    end
    drive(1'b1, 1'b0, 1'b0, 32'h200);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t2.full_count", 32'(bus.count), 32'd4);
      chk("t2.full_ack",   32'(bus.decoded_instr_ack), 32'd0);
      step("t2.hold");
    end
    drive(1'b1, 1'b1, 1'b0, 32'h200);
    #1;
    chk("t2.ack_not_comb", 32'(bus.decoded_instr_ack), 32'd0);
    chk("t2.pop_head",     bus.issue_orig_instr, 32'h100);
    step("t2.pop");
    drive(1'b1, 1'b0, 1'b0, 32'h200);
    #1;
    chk("t2.ack_after", 32'(bus.decoded_instr_ack), 32'd1);
    step("t2.accept");
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("t2.count_end", 32'(bus.count), 32'd4);
    step("t2.idle");

    // 3: push and pop together at count=2
    reset_dut();
    drive(1'b1, 1'b0, 1'b0, 32'hA1);
    first_sbe = bus.decoded_instr;
    step("t3.fill0");
    drive(1'b1, 1'b0, 1'b0, 32'hA2);
    step("t3.fill1");
    drive(1'b1, 1'b1, 1'b0, 32'hC);
    step("t3.pushpop");
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("t3.count", 32'(bus.count), 32'd2);
    chk("t3.pv",    32'(bus.issue_prev_valid), 32'd1);
    chk("t3.prev",  32'(bus.issue_instr_prev), 32'(first_sbe));
    chk("t3.head",  bus.issue_orig_instr, 32'hA2);
    step("t3.idle");

    // 4: pointer wrap with eight in-order entries
    reset_dut();
    drive(1'b1, 1'b0, 1'b0, 32'h1);
    step("t4.first");
    for (int i = 2; i <= 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'(i));
      #1;
      chk("t4.order", bus.issue_orig_instr, 32'(i - 1));
      step("t4.pair");
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    chk("t4.last", bus.issue_orig_instr, 32'h8);
    step("t4.drain");
    chk("t4.empty", 32'(bus.count), 32'd0);

    // 5: flush beats push and pop
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h300 + 32'(i));
      step("t5.fill");
    end
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step("t5.pop_for_prev");
    drive(1'b1, 1'b1, 1'b1, 32'h55);
    #1;
    chk("t5.ack_in_flush", 32'(bus.decoded_instr_ack), 32'd0);
    step("t5.flush");
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("t5.count", 32'(bus.count), 32'd0);
    chk("t5.valid", 32'(bus.issue_instr_valid), 32'd0);
    chk("t5.pv",    32'(bus.issue_prev_valid), 32'd0);
    step("t5.idle");

    // 6: asynchronous reset mid-cycle
    reset_dut();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h400 + 32'(i));
      step("t6.fill");
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6.count", 32'(bus.count), 32'd0);
    chk("t6.valid", 32'(bus.issue_instr_valid), 32'd0);
    chk("t6.ack",   32'(bus.decoded_instr_ack), 32'd1);
    q.delete();
    prev_m   = 16'h0;
    prev_v_m = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step("t6.after");

    // Randomized traffic: fill-biased phase, then drain-biased phase
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      if (i < 200)
        drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 29) == 0), $urandom);
      else
        drive(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 29) == 0), $urandom);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
